// File: rtl/out_accum.sv
// Output accumulator / writeback stage behind the Winograd PE: sums same-tag 6x6
// result tiles in two ping-pong banks and drains finished tiles row by row to memory.
module out_accum #(
    parameter int ACC_W = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [4:0]                 cfg_id_count_i,
    input  logic signed [5:0][5:0][15:0] result_tile_i,
    input  logic                       result_valid_i,
    input  logic [7:0]                 result_od_i,
    input  logic [8:0]                 result_x_i,
    input  logic [8:0]                 result_y_i,
    input  logic                       result_size_type_i,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic signed [5:0][15:0]    mem_wdata_o,
    output logic [5:0]                 mem_wmask_o,
    output logic [7:0]                 mem_od_o,
    output logic [8:0]                 mem_row_o,
    output logic [8:0]                 mem_col_o,
    output logic                       tile_done_o,
    output logic                       err_tag_o,
    output logic                       err_ovf_o,
    input  logic                       err_clr_i
);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_ACCUM, BANK_FULL, BANK_DRAIN} bank_state_e;
    typedef enum logic {DR_IDLE, DR_ROW} drain_state_e;
    typedef struct packed {
        logic [7:0] od;
        logic [8:0] x;
        logic [8:0] y;
    } tag_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    bank_state_e             bank_state  [2];
    logic signed [ACC_W-1:0] acc         [2][6][6];
    tag_t                    bank_tag    [2];
    logic                    bank_type   [2];
    logic [4:0]              bank_target [2];
    logic [4:0]              bank_count  [2];
    logic                    accum_sel;
    logic                    drain_sel;

    drain_state_e drain_state, drain_state_nxt;
    logic [2:0]   row_q, row_nxt;

    logic signed [ACC_W-1:0] tile_ext [6][6];
    tag_t        in_tag;
    bank_state_e acc_state;
    logic [4:0]  cfg_target;
    logic [4:0]  count_nxt;
    logic        accept_new, accept_add, tag_err, ovf_err, group_done;
    logic        drain_start, row_hs, last_row, drain_done;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'sh7fff;
        else if (v < SAT_MIN) return 16'sh8000;
        else                  return v[15:0];
    endfunction

    assign in_tag     = {result_od_i, result_x_i, result_y_i};
    assign acc_state  = bank_state[accum_sel];
    assign cfg_target = (cfg_id_count_i == 5'd0) ? 5'd1 : cfg_id_count_i;

    always_comb begin
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                tile_ext[r][c] = ACC_W'($signed(result_tile_i[r][c]));
    end

    // NOTE: every signal driven in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        accept_new = 1'b0;
        accept_add = 1'b0;
        tag_err    = 1'b0;
        ovf_err    = 1'b0;
        if (result_valid_i) begin
            unique case (acc_state)
                BANK_EMPTY: accept_new = 1'b1;
                BANK_ACCUM: begin
                    accept_add = (bank_tag[accum_sel] == in_tag);
                    tag_err    = (bank_tag[accum_sel] != in_tag);
                end
                default:    ovf_err = 1'b1;
            endcase
        end
        count_nxt  = accept_new ? 5'd1 : bank_count[accum_sel] + 5'd1;
        group_done = (accept_new && cfg_target == 5'd1) ||
                     (accept_add && count_nxt == bank_target[accum_sel]);
    end

    // Drain side only touches FULL/DRAIN banks, accumulate side only EMPTY/ACCUM,
    // so the two never update the same bank in one cycle.
    assign drain_start = (drain_state == DR_IDLE) && (bank_state[drain_sel] == BANK_FULL);
    assign row_hs      = mem_valid_o && mem_ready_i;
    assign last_row    = (row_q == (bank_type[drain_sel] ? 3'd3 : 3'd5));
    assign drain_done  = row_hs && last_row;

    always_comb begin
        drain_state_nxt = drain_state;
        row_nxt         = row_q;
        unique case (drain_state)
            DR_IDLE: if (drain_start) begin
                drain_state_nxt = DR_ROW;
                row_nxt         = 3'd0;
            end
            DR_ROW: if (row_hs) begin
                if (last_row) begin
                    drain_state_nxt = DR_IDLE;
                    row_nxt         = 3'd0;
                end else begin
                    row_nxt = row_q + 3'd1;
                end
            end
            default: drain_state_nxt = DR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_state <= DR_IDLE;
            row_q       <= 3'd0;
        end else begin
            drain_state <= drain_state_nxt;
            row_q       <= row_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accum_sel <= 1'b0;
            drain_sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_state[b]  <= BANK_EMPTY;
                bank_tag[b]    <= '0;
                bank_type[b]   <= 1'b0;
                bank_target[b] <= 5'd0;
                bank_count[b]  <= 5'd0;
                // NOTE: the accumulator array is reset because a reset must discard all tile contents.
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        acc[b][r][c] <= '0;
            end
        end else begin
            if (accept_new) begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        acc[accum_sel][r][c] <= tile_ext[r][c];
                bank_tag[accum_sel]    <= in_tag;
                bank_type[accum_sel]   <= result_size_type_i;
                bank_target[accum_sel] <= cfg_target;
                bank_count[accum_sel]  <= count_nxt;
                bank_state[accum_sel]  <= group_done ? BANK_FULL : BANK_ACCUM;
            end else if (accept_add) begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        acc[accum_sel][r][c] <= acc[accum_sel][r][c] + tile_ext[r][c];
                bank_count[accum_sel] <= count_nxt;
                if (group_done) bank_state[accum_sel] <= BANK_FULL;
            end
            if (group_done) accum_sel <= ~accum_sel;

            if (drain_start) bank_state[drain_sel] <= BANK_DRAIN;
            if (drain_done) begin
                bank_state[drain_sel] <= BANK_EMPTY;
                drain_sel             <= ~drain_sel;
            end
        end
    end

    // A same-cycle error event beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_tag_o <= 1'b0;
            err_ovf_o <= 1'b0;
        end else begin
            if (tag_err)        err_tag_o <= 1'b1;
            else if (err_clr_i) err_tag_o <= 1'b0;
            if (ovf_err)        err_ovf_o <= 1'b1;
            else if (err_clr_i) err_ovf_o <= 1'b0;
        end
    end

    assign mem_valid_o = (drain_state == DR_ROW);
    assign tile_done_o = drain_done;

    always_comb begin
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        mem_od_o    = '0;
        mem_row_o   = '0;
        mem_col_o   = '0;
        if (mem_valid_o) begin
            for (int c = 0; c < 6; c++)
                if (c < 4 || !bank_type[drain_sel])
                    mem_wdata_o[c] = sat16(acc[drain_sel][row_q][c]);
            mem_wmask_o = bank_type[drain_sel] ? 6'h0F : 6'h3F;
            mem_od_o    = bank_tag[drain_sel].od;
            mem_row_o   = bank_tag[drain_sel].x + {6'd0, row_q};
            mem_col_o   = bank_tag[drain_sel].y;
        end
    end

endmodule

// File: tb/tb_out_accum.sv
// Directed self-checking bench for out_accum: single/multi-tile groups, saturation,
// ping-pong with backpressure, tag mismatch, reset mid-drain and index wrap.
module tb_out_accum;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [4:0]                   cfg_id_count_i;
    logic signed [5:0][5:0][15:0] result_tile_i;
    logic                         result_valid_i;
    logic [7:0]                   result_od_i;
    logic [8:0]                   result_x_i, result_y_i;
    logic                         result_size_type_i;
    logic                         mem_valid_o, mem_ready_i;
    logic signed [5:0][15:0]      mem_wdata_o;
    logic [5:0]                   mem_wmask_o;
    logic [7:0]                   mem_od_o;
    logic [8:0]                   mem_row_o, mem_col_o;
    logic                         tile_done_o, err_tag_o, err_ovf_o, err_clr_i;

    int checks   = 0;
    int failures = 0;

    out_accum #(.ACC_W(20)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_id_count_i(cfg_id_count_i),
        .result_tile_i(result_tile_i), .result_valid_i(result_valid_i),
        .result_od_i(result_od_i), .result_x_i(result_x_i), .result_y_i(result_y_i),
        .result_size_type_i(result_size_type_i), .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_od_o(mem_od_o), .mem_row_o(mem_row_o), .mem_col_o(mem_col_o),
        .tile_done_o(tile_done_o), .err_tag_o(err_tag_o), .err_ovf_o(err_ovf_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one tile for exactly one clock edge; returns at the negedge after that edge.
    task automatic send_tile(input logic [15:0] v, input logic [7:0] od,
                             input logic [8:0] x, input logic [8:0] y, input logic typ);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                result_tile_i[r][c] = v;
        result_od_i        = od;
        result_x_i         = x;
        result_y_i         = y;
        result_size_type_i = typ;
        result_valid_i     = 1'b1;
        @(negedge clk);
        result_valid_i     = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, mem_valid_o, 0);
        check({tag, "_wdata"}, mem_wdata_o, 0);
        check({tag, "_wmask"}, mem_wmask_o, 0);
        check({tag, "_od"},    mem_od_o, 0);
        check({tag, "_row"},   mem_row_o, 0);
        check({tag, "_col"},   mem_col_o, 0);
        check({tag, "_done"},  tile_done_o, 0);
        check({tag, "_etag"},  err_tag_o, 0);
        check({tag, "_eovf"},  err_ovf_o, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!mem_valid_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", mem_valid_o, 1);
    endtask

    // Expects a full drain with mem_ready_i held high: one row per cycle, then an idle gap.
    task automatic expect_drain(input logic [15:0] val, input logic [7:0] od,
                                input logic [8:0] x, input logic [8:0] y, input logic typ);
        int nrows = typ ? 4 : 6;
        logic [8:0]  erow;
        logic [15:0] edata;
        wait_valid(20);
        for (int r = 0; r < nrows; r++) begin
            erow = x + 9'(r);
            check("row_valid", mem_valid_o, 1);
            check("row_od",    mem_od_o, od);
            check("row_idx",   mem_row_o, erow);
            check("row_col",   mem_col_o, y);
            check("row_mask",  mem_wmask_o, typ ? 6'h0F : 6'h3F);
            for (int c = 0; c < 6; c++) begin
                edata = (c < nrows) ? val : 16'h0000;
                check("row_data", mem_wdata_o[c], edata);
            end
            check("tile_done", tile_done_o, (r == nrows - 1));
            @(negedge clk);
        end
        check("drain_gap", mem_valid_o, 0);
    endtask

    initial begin
        reset_n            = 1'b0;
        cfg_id_count_i     = 5'd1;
        result_tile_i      = '0;
        result_valid_i     = 1'b0;
        result_od_i        = '0;
        result_x_i         = '0;
        result_y_i         = '0;
        result_size_type_i = 1'b0;
        mem_ready_i        = 1'b1;
        err_clr_i          = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single tile, 6x6, with first-row latency
        cfg_id_count_i = 5'd1;
        send_tile(16'd100, 8'd3, 9'd8, 9'd12, 1'b0);
        check("lat_idle", mem_valid_o, 0);
        @(negedge clk);
        check("lat_rise", mem_valid_o, 1);
        expect_drain(16'd100, 8'd3, 9'd8, 9'd12, 1'b0);

        // Four-tile group, 4x4; nothing drains before the 4th tile
        cfg_id_count_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            send_tile(16'd1000, 8'd5, 9'd20, 9'd30, 1'b1);
            check("early_valid", mem_valid_o, 0);
        end
        send_tile(16'd1000, 8'd5, 9'd20, 9'd30, 1'b1);
        expect_drain(16'd4000, 8'd5, 9'd20, 9'd30, 1'b1);

        // Saturation both ways over 16 tiles
        cfg_id_count_i = 5'd16;
        for (int i = 0; i < 16; i++) send_tile(16'd30000, 8'd7, 9'd1, 9'd2, 1'b0);
        expect_drain(16'h7FFF, 8'd7, 9'd1, 9'd2, 1'b0);
        for (int i = 0; i < 16; i++) send_tile(-16'sd30000, 8'd7, 9'd1, 9'd2, 1'b0);
        expect_drain(16'h8000, 8'd7, 9'd1, 9'd2, 1'b0);

        // Ping-pong with backpressure: A, B stored, C dropped
        cfg_id_count_i = 5'd1;
        mem_ready_i    = 1'b0;
        send_tile(16'd11, 8'd1, 9'd0,  9'd0, 1'b0);
        send_tile(16'd22, 8'd2, 9'd40, 9'd4, 1'b0);
        send_tile(16'd33, 8'd3, 9'd60, 9'd6, 1'b0);
        check("ovf_set", err_ovf_o, 1);
        check("ovf_no_tag", err_tag_o, 0);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", mem_valid_o, 1);
            check("bp_row",   mem_row_o, 0);
            check("bp_data",  mem_wdata_o[0], 16'd11);
            @(negedge clk);
        end
        mem_ready_i = 1'b1;
        expect_drain(16'd11, 8'd1, 9'd0,  9'd0, 1'b0);
        expect_drain(16'd22, 8'd2, 9'd40, 9'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("no_c_drain", mem_valid_o, 0);
            @(negedge clk);
        end
        check("ovf_sticky", err_ovf_o, 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("ovf_clr", err_ovf_o, 0);

        // Tag mismatch: middle tile ignored, group still sums 7 + 9
        cfg_id_count_i = 5'd2;
        send_tile(16'd7,  8'd1, 9'd0, 9'd0, 1'b0);
        send_tile(16'd50, 8'd2, 9'd0, 9'd0, 1'b0);
        check("tag_err", err_tag_o, 1);
        check("tag_nodrain", mem_valid_o, 0);
        send_tile(16'd9,  8'd1, 9'd0, 9'd0, 1'b0);
        expect_drain(16'd16, 8'd1, 9'd0, 9'd0, 1'b0);
        check("tag_sticky", err_tag_o, 1);

        // Reset while row 2 is presented
        cfg_id_count_i = 5'd1;
        send_tile(16'd5, 8'd9, 9'd100, 9'd7, 1'b0);
        wait_valid(20);
        repeat (2) @(negedge clk);
        check("pre_rst_row", mem_row_o, 9'd102);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_valid", mem_valid_o, 0);
            @(negedge clk);
        end

        // cfg=0 acts as 1; 4x4 negative value; row index wraps 511 -> 0
        cfg_id_count_i = 5'd0;
        send_tile(-16'sd7, 8'd4, 9'd511, 9'd3, 1'b1);
        expect_drain(16'hFFF9, 8'd4, 9'd511, 9'd3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
